// File: rtl/fpalu_arbiter.sv
// fpalu_arbiter
// Shares one floating-point ALU between two requesters. A round-robin
// arbiter picks a requester in IDLE and presents its operands to the ALU.
// A multiply result is taken after a fixed latency. An add result is taken
// on a rising edge of alu_done. The result is then returned with the id of
// the requester that owns it.
//
// Optional feature: define FPALU_ARB_TIMEOUT_EN to abort any operation that
// stays in WAIT for TIMEOUT cycles. The abort returns rsp_err=1. Without the
// macro an add waits for alu_done indefinitely and rsp_err is tied to 0.
//
// Parameters
//   MUL_LAT  multiply wait cycles (1..255)
//   TIMEOUT  maximum WAIT cycles when FPALU_ARB_TIMEOUT_EN is defined (1..1023)
// Ports
//   clock, reset            clock and synchronous active-low reset
//   req0/1, op0/1           request strobes and op select (1=mul, 0=add)
//   a0/b0, a1/b1            single-precision operands per requester
//   gnt0/1                  one-cycle grant pulse
//   alu_a, alu_b, alu_op    operands and op presented to the shared ALU
//   alu_result, alu_flow    ALU result and overflow flag
//   alu_done                ALU add-complete flag
//   rsp_valid, rsp_id       response strobe and owning requester
//   rsp_result, rsp_flow    captured result and overflow flag
//   rsp_err                 operation was aborted by timeout
module fpalu_arbiter #(
  parameter int MUL_LAT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        op0,
  input  logic        op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_flow,
  input  logic        alu_done,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_flow,
  output logic        rsp_err
);

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               prio, prio_d;      // requester favoured on a tie
  logic               owner, owner_d;    // requester of the operation in flight
  logic               done_q;            // alu_done delayed one cycle
  logic               done_rise;
  logic               win;
  logic               gnt0_d, gnt1_d;
  logic [31:0]        alu_a_d, alu_b_d;
  logic               alu_op_d;
  logic               rsp_valid_d, rsp_id_d;
  logic [31:0]        rsp_result_d;
  logic               rsp_flow_d;
`ifdef FPALU_ARB_TIMEOUT_EN
  logic               rsp_err_q, rsp_err_d;
`endif

  assign done_rise = alu_done && !done_q;

  // Tie goes to prio. With a single request the requester that asks wins.
  assign win = (req0 && req1) ? prio : !req0;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    prio_d       = prio;
    owner_d      = owner;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_op_d     = alu_op;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id;
    rsp_result_d = rsp_result;
    rsp_flow_d   = rsp_flow;
`ifdef FPALU_ARB_TIMEOUT_EN
    rsp_err_d    = rsp_err_q;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_d  = win;
          prio_d   = !win;
          gnt0_d   = !win;
          gnt1_d   = win;
          alu_a_d  = win ? a1 : a0;
          alu_b_d  = win ? b1 : b0;
          alu_op_d = win ? op1 : op0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt + 1'b1;
        // A multiply completes on its last WAIT cycle. An add completes on a
        // fresh alu_done edge. done_q already holds any level left over from
        // IDLE or ISSUE, so a stale level cannot fake an edge here.
        if (alu_op ? (cnt == CNT_W'(MUL_LAT - 1)) : done_rise) begin
          rsp_result_d = alu_result;
          rsp_flow_d   = alu_flow;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = owner;
`ifdef FPALU_ARB_TIMEOUT_EN
          rsp_err_d    = 1'b0;
`endif
          state_d      = RESP;
        end
`ifdef FPALU_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_flow_d   = 1'b0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = owner;
          state_d      = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      prio       <= 1'b0;
      owner      <= 1'b0;
      done_q     <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flow   <= 1'b0;
`ifdef FPALU_ARB_TIMEOUT_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      prio       <= prio_d;
      owner      <= owner_d;
      done_q     <= alu_done;
      gnt0       <= gnt0_d;
      gnt1       <= gnt1_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_op     <= alu_op_d;
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= rsp_id_d;
      rsp_result <= rsp_result_d;
      rsp_flow   <= rsp_flow_d;
`ifdef FPALU_ARB_TIMEOUT_EN
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

`ifdef FPALU_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpalu_arbiter.sv
// Directed bench for fpalu_arbiter. The bench plays the ALU itself and knows
// the result each operation should return. That expected response is queued
// at grant time and compared when rsp_valid appears.
module tb_fpalu_arbiter;

  localparam int MUL_LAT = 4;
  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1;
  logic [31:0] alu_a, alu_b;
  logic        alu_op;
  logic [31:0] alu_result = '0;
  logic        alu_flow = 1'b0;
  logic        alu_done = 1'b0;
  logic        rsp_valid, rsp_id, rsp_flow, rsp_err;
  logic [31:0] rsp_result;

  fpalu_arbiter #(.MUL_LAT(MUL_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flow(alu_flow), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flow(rsp_flow), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int rsp_cnt = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        flow;
    logic        err;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] res, input logic flow, input logic err);
    exp_t e;
    e.id = id; e.res = res; e.flow = flow; e.err = err;
    sb.push_back(e);
  endtask

  // Response scoreboard and grant exclusivity monitor.
  always @(negedge clock) begin
    exp_t e;
    if (gnt0 || gnt1)
      check("one_gnt", 32'({1'b0, gnt0} + {1'b0, gnt1}), 32'd1);
    if (rsp_valid) begin
      rsp_cnt++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_rsp observed=rsp_valid expected=none id=%0d", rsp_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", rsp_result, e.res);
        check("rsp_flow", 32'(rsp_flow), 32'(e.flow));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic wait_gnt(input logic id, output int g, output bit ok);
    ok = 1'b0;
    g = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ((id == 1'b0) ? gnt0 : gnt1) begin
        ok = 1'b1;
        g = cyc;
        break;
      end
    end
    if (!ok) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_any(output logic id, output int g, output bit ok);
    ok = 1'b0;
    g = 0;
    id = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (gnt0 || gnt1) begin
        ok = 1'b1;
        g = cyc;
        id = gnt1;
        break;
      end
    end
    if (!ok) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int exp_cyc);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        check("rsp_cycle", 32'(cyc), 32'(exp_cyc));
        return;
      end
    end
    check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
  endtask

  // One request from a single requester. dly is the number of cycles from the
  // grant cycle to the alu_done rise (add only). With stale set, alu_done
  // already sits high from before the request and drops two cycles after gnt.
  task automatic do_op(input logic id, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input logic flw, input int dly, input bit stale);
    int g;
    bit ok;
    alu_result = res;
    alu_flow   = flw;
    alu_done   = stale;
    if (id == 1'b0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else            begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    wait_gnt(id, g, ok);
    req0 = 1'b0;
    req1 = 1'b0;
    if (!ok) return;
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", 32'(alu_op), 32'(op));
    push(id, res, flw, 1'b0);
    if (op == 1'b0) begin
      if (stale) begin
        while (cyc < g + 2) @(negedge clock);
        alu_done = 1'b0;
      end
      while (cyc < g + dly) @(negedge clock);
      alu_done = 1'b1;
      wait_rsp(g + dly + 1);
    end else begin
      wait_rsp(g + MUL_LAT + 1);
    end
    alu_done = 1'b0;
    @(negedge clock);
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
    check("rsp_hold", rsp_result, res);
  endtask

  initial begin
    int   g, g_prev, snap;
    bit   ok;
    logic id;
    logic exp_order [3];
    logic [31:0] rr_res [3];
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
    rr_res[0] = 32'h3F800001; rr_res[1] = 32'h3F800002; rr_res[2] = 32'h3F800003;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_flow", 32'(rsp_flow), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Multiply 1.0 * 2.0 from requester 0
    do_op(1'b0, 1'b1, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 0, 1'b0);
    // Add 1.0 + 1.0 from requester 1, done rises 7 cycles after the grant
    do_op(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 7, 1'b0);
    // Overflowing multiply: flag and result passed through
    do_op(1'b0, 1'b1, 32'h7F720080, 32'h7F7E4280, 32'h7F800000, 1'b1, 0, 1'b0);
    // Add with a stale done level held through IDLE and ISSUE
    do_op(1'b1, 1'b0, 32'h40400000, 32'h40800000, 32'h40E00000, 1'b0, 5, 1'b1);

    // Round robin with both requests held: order 0,1,0
    reset_pulse();
    op0 = 1'b1; a0 = 32'h11111111; b0 = 32'h22222222;
    op1 = 1'b1; a1 = 32'h33333333; b1 = 32'h44444444;
    req0 = 1'b1; req1 = 1'b1;
    g_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_any(id, g, ok);
      if (!ok) break;
      alu_result = rr_res[k];
      alu_flow   = 1'b0;
      if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
      check("rr_order", 32'(id), 32'(exp_order[k]));
      check("rr_alu_a", alu_a, exp_order[k] ? 32'h33333333 : 32'h11111111);
      if (k > 0) check("rr_interval", 32'(g - g_prev), 32'(MUL_LAT + 3));
      push(exp_order[k], rr_res[k], 1'b0, 1'b0);
      g_prev = g;
    end
    req0 = 1'b0; req1 = 1'b0;
    if (ok) wait_rsp(g_prev + MUL_LAT + 1);
    @(negedge clock);

    // Add whose done never rises
    alu_result = 32'h12345678;
    alu_flow   = 1'b1;
    alu_done   = 1'b0;
    op0 = 1'b0; a0 = 32'h3F800000; b0 = 32'h3F800000;
    req0 = 1'b1;
    wait_gnt(1'b0, g, ok);
    req0 = 1'b0;
`ifdef FPALU_ARB_TIMEOUT_EN
    if (ok) begin
      push(1'b0, 32'd0, 1'b0, 1'b1);
      wait_rsp(g + TIMEOUT + 1);
      @(negedge clock);
      check("err_hold", 32'(rsp_err), 32'd1);
    end
`else
    snap = rsp_cnt;
    repeat (200) @(negedge clock);
    check("no_rsp_without_done", 32'(rsp_cnt - snap), 32'd0);
    check("err_const", 32'(rsp_err), 32'd0);
`endif
    alu_flow = 1'b0;
    reset_pulse();

    // Reset during WAIT of a multiply discards it
    alu_result = 32'hDEADBEEF;
    op0 = 1'b1; a0 = 32'h40000000; b0 = 32'h40400000;
    req0 = 1'b1;
    wait_gnt(1'b0, g, ok);
    req0 = 1'b0;
    @(negedge clock);
    snap = rsp_cnt;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wrst_alu_a", alu_a, 32'd0);
    check("wrst_alu_op", 32'(alu_op), 32'd0);
    repeat (10) @(negedge clock);
    check("wrst_no_rsp", 32'(rsp_cnt - snap), 32'd0);
    do_op(1'b0, 1'b1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 0, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
